// File: rtl/img_pkg.sv
// Shared constants, FSM state type and coordinate helpers for the
// 16x16 binary template capture block.
package img_pkg;

  localparam int HALVING = 4;                    // log2 of cell edge in pixels
  localparam int GRID    = 16;                   // cells per row / column
  localparam int PIX_W   = 10;                   // grey-level width
  localparam int WIN     = 256;                  // capture window edge in pixels
  localparam int COORD_W = 13;                   // pixel coordinate width
  localparam int CELLS   = GRID * GRID;          // template entries
  localparam int IDX_W   = $clog2(GRID);         // cell row / column index width
  localparam int ACC_W   = PIX_W + 2 * HALVING;  // one cell worth of pixels

  localparam logic [PIX_W-1:0] WHITE = 10'd255;
  localparam logic [PIX_W-1:0] BLACK = 10'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_COMMIT
  } state_t;

  // True when a pixel coordinate lies inside the top-left capture window.
  function automatic logic inWindow(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    return (x < COORD_W'(WIN)) && (y < COORD_W'(WIN));
  endfunction

  // Cell column (or row) that a pixel coordinate falls into.
  function automatic logic [IDX_W-1:0] cellOf(input logic [COORD_W-1:0] p);
    return IDX_W'(p >> HALVING);
  endfunction

  // Flat template index row*GRID+col; only meaningful inside the window.
  function automatic logic [2*IDX_W-1:0] cellIndex(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
    return (2 * IDX_W)'(((y >> HALVING) << IDX_W) + (x >> HALVING));
  endfunction

endpackage

// File: rtl/img_template_capture_if.sv
// Pixel stream, control and template read port of img_template_capture.
// The master side drives pixels, control and read coordinates; the slave
// side is the capture block itself.
interface img_template_capture_if;
  import img_pkg::*;

  logic               iSTART;
  logic [PIX_W-1:0]   iTHRESH;
  logic               iDVAL;
  logic [COORD_W-1:0] iX;
  logic [COORD_W-1:0] iY;
  logic [PIX_W-1:0]   iGRAY;
  logic [COORD_W-1:0] iRX;
  logic [COORD_W-1:0] iRY;
  logic [PIX_W-1:0]   oVAL;
  logic               oBUSY;
  logic               oDONE;
  logic               oTPL_OK;

  modport master (
    output iSTART, iTHRESH, iDVAL, iX, iY, iGRAY, iRX, iRY,
    input  oVAL, oBUSY, oDONE, oTPL_OK
  );

  modport slave (
    input  iSTART, iTHRESH, iDVAL, iX, iY, iGRAY, iRX, iRY,
    output oVAL, oBUSY, oDONE, oTPL_OK
  );

endinterface

// File: rtl/img_cell_accum.sv
// Bank of per-column cell accumulators. Pixels of one cell row arrive
// interleaved across the 16 cell columns, so one running sum per column
// is enough: it is emptied when its cell closes and reused for the same
// column of the next cell row.
module img_cell_accum
  import img_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iAddEn,    // accepted beat: add iData to column iCol
  input  logic             iClearAll, // frame (re)start: empty every column
  input  logic             iClose,    // beat closes the cell: empty column iCol
  input  logic [IDX_W-1:0] iCol,
  input  logic [PIX_W-1:0] iData,
  output logic [ACC_W-1:0] oSum       // column sum including the current beat
);

  logic [ACC_W-1:0] acc [GRID];

  assign oSum = acc[iCol] + ACC_W'(iData);

  // Accumulate accepted beats; empty a column on cell close, all on restart.
  // NOTE: the accumulator array sits behind an asynchronous reset so that a
  // reset mid-capture cannot leak partial sums into the next frame; a bank
  // with no such requirement would be left unreset to stay a plain RAM.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < GRID; i++) acc[i] <= '0;
    end else begin
      if (iClearAll) begin
        for (int i = 0; i < GRID; i++) acc[i] <= '0;
      end
      // NOTE: non-blocking assignments make the later per-column write win
      // over the bulk clear above, and keep every read of acc[] in this
      // cycle on the pre-edge value.
      if (iAddEn) begin
        if (iClose)         acc[iCol] <= '0;
        else if (iClearAll) acc[iCol] <= ACC_W'(iData);
        else                acc[iCol] <= oSum;
      end
    end
  end

endmodule

// File: rtl/img_template_capture.sv
// Write side of the 16x16 binary template. Snoops the grey pixel stream,
// averages every 16x16 cell of the top-left 256x256 window, thresholds
// each average to BLACK/WHITE into a shadow map and, once the whole frame
// is in, copies the shadow into the live template in a single cycle. The
// live template is served back through a registered X/Y read port.
module img_template_capture
  import img_pkg::*;
(
  input  logic                  iCLK,
  input  logic                  iRST_N,
  img_template_capture_if.slave bus
);

  state_t           state;
  logic [PIX_W-1:0] thrQ;
  logic [CELLS-1:0] shadow;
  logic [CELLS-1:0] tpl;

  logic             accept;
  logic             atOrigin;
  logic             cellEnd;
  logic             frameEnd;
  logic             addEn;
  logic             clearAll;
  logic [ACC_W-1:0] closeSum;
  logic [ACC_W-1:0] thrSum;
  logic             cellWhite;

  // Beat qualification: only valid beats inside the window are used.
  assign accept   = bus.iDVAL && inWindow(bus.iX, bus.iY);
  assign atOrigin = accept && (bus.iX == '0) && (bus.iY == '0);
  assign cellEnd  = accept && (&bus.iX[HALVING-1:0]) && (&bus.iY[HALVING-1:0]);
  assign frameEnd = cellEnd && (&bus.iX[7:0]) && (&bus.iY[7:0]);

  // The origin beat that starts (or restarts) a capture is itself summed,
  // after every column has been emptied.
  assign addEn    = ((state == ST_CAPTURE) && accept) ||
                    ((state == ST_ARMED) && atOrigin);
  assign clearAll = ((state == ST_CAPTURE) || (state == ST_ARMED)) && atOrigin;

  img_cell_accum u_accum (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iAddEn    (addEn),
    .iClearAll (clearAll),
    .iClose    (cellEnd),
    .iCol      (cellOf(bus.iX)),
    .iData     (bus.iGRAY),
    .oSum      (closeSum)
  );

  // The cell average is sum>>8 truncated; comparing it against the threshold
  // is the same as comparing the full sum against threshold<<8.
  assign thrSum    = {thrQ, {(2 * HALVING){1'b0}}};
  assign cellWhite = (closeSum >= thrSum);

  // Capture sequencer with registered busy / done / template-valid flags.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= ST_IDLE;
      thrQ        <= '0;
      bus.oBUSY   <= 1'b0;
      bus.oDONE   <= 1'b0;
      bus.oTPL_OK <= 1'b0;
    end else begin
      bus.oDONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.iSTART) begin
            state     <= ST_ARMED;
            thrQ      <= bus.iTHRESH;
            bus.oBUSY <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (atOrigin) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (frameEnd) begin
            state     <= ST_COMMIT;
            bus.oDONE <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state       <= ST_IDLE;
          bus.oBUSY   <= 1'b0;
          bus.oTPL_OK <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          bus.oBUSY <= 1'b0;
        end
      endcase
    end
  end

  // Shadow map fills as cells close; the live template copies it on commit.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      shadow <= '0;
      tpl    <= '0;
    end else begin
      if ((state == ST_CAPTURE) && cellEnd) begin
        shadow[cellIndex(bus.iX, bus.iY)] <= cellWhite;
      end
      if (state == ST_COMMIT) begin
        tpl <= shadow;
      end
    end
  end

  // Registered template read; coordinates outside the window read BLACK.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bus.oVAL <= '0;
    end else begin
      bus.oVAL <= (inWindow(bus.iRX, bus.iRY) && tpl[cellIndex(bus.iRX, bus.iRY)])
                  ? WHITE : BLACK;
    end
  end

endmodule

// File: tb/tb_img_template_capture.sv
// Directed bench for img_template_capture. Frames are sent sparsely: each
// cell receives exactly 8 in-cell beats (the last one on its closing pixel),
// so a cell sum is 8 grey values and its average is that sum >> 8. Inputs
// are driven and outputs sampled on the falling clock edge.
module tb_img_template_capture;
  import img_pkg::*;

  logic iCLK;
  logic iRST_N;

  img_template_capture_if bus();

  img_template_capture dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nFails  = 0;
  int doneCnt = 0;

  int               grayA [CELLS];  // grey of even beats of each cell
  int               grayB [CELLS];  // grey of odd beats of each cell
  logic [CELLS-1:0] diagMap;
  logic [PIX_W-1:0] v;
  int               d0;

  // Count commit pulses, sampled before the edge updates them.
  always @(posedge iCLK) if (bus.oDONE === 1'b1) doneCnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [CELLS-1:0] got,
                       input logic [CELLS-1:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic vld, input int x, input int y, input int g);
    bus.iDVAL = vld;
    bus.iX    = COORD_W'(x);
    bus.iY    = COORD_W'(y);
    bus.iGRAY = PIX_W'(g);
    @(negedge iCLK);
  endtask

  task automatic arm(input int thr);
    bus.iSTART  = 1'b1;
    bus.iTHRESH = PIX_W'(thr);
    @(negedge iCLK);
    bus.iSTART  = 1'b0;
    check("arm_busy", CELLS'(bus.oBUSY), CELLS'(1));
  endtask

  task automatic setUniform(input int a, input int b);
    for (int i = 0; i < CELLS; i++) begin
      grayA[i] = a;
      grayB[i] = b;
    end
  endtask

  task automatic setDiag(input int on, input int off);
    for (int i = 0; i < CELLS; i++) begin
      grayA[i] = ((i / GRID) == (i % GRID)) ? on : off;
      grayB[i] = grayA[i];
    end
  endtask

  // Eight beats per cell for cell rows rowLo..rowHi; cell (0,0) starts at
  // the origin. Optional junk beats (outside the window or not valid) are
  // placed mid-cell on coordinates that would close a cell if accepted.
  task automatic sendCells(input int rowLo, input int rowHi, input bit junk);
    for (int cy = rowLo; cy <= rowHi; cy++) begin
      for (int cx = 0; cx < GRID; cx++) begin
        for (int k = 0; k < 8; k++) begin
          int idx;
          int g;
          idx = cy * GRID + cx;
          g   = ((k % 2) == 1) ? grayB[idx] : grayA[idx];
          if (k == 7)                  beat(1'b1, cx * 16 + 15, cy * 16 + 15, g);
          else if (idx == 0 && k == 0) beat(1'b1, 0, 0, g);
          else                         beat(1'b1, cx * 16 + 1, cy * 16 + 1, g);
          if (junk && k == 3) begin
            beat(1'b1, 271, cy * 16 + 15, 1023);
            beat(1'b1, 300, cy * 16 + 15, 1023);
            beat(1'b1, cx * 16 + 15, 271, 1023);
            beat(1'b0, cx * 16 + 15, cy * 16 + 15, 1023);
          end
        end
      end
    end
    bus.iDVAL = 1'b0;
  endtask

  // Called right after the last beat: checks the commit cycle and the two
  // following cycles, optionally tracking the read of the current iRX/iRY.
  task automatic endFrame(input bit track, input int oldV, input int newV);
    bus.iDVAL = 1'b0;
    check("done_t1", CELLS'(bus.oDONE), CELLS'(1));
    check("busy_t1", CELLS'(bus.oBUSY), CELLS'(1));
    if (track) check("rd_t1_old", CELLS'(bus.oVAL), CELLS'(oldV));
    @(negedge iCLK);
    check("done_t2", CELLS'(bus.oDONE), CELLS'(0));
    check("busy_t2", CELLS'(bus.oBUSY), CELLS'(0));
    check("tplok_t2", CELLS'(bus.oTPL_OK), CELLS'(1));
    if (track) check("rd_t2_old", CELLS'(bus.oVAL), CELLS'(oldV));
    @(negedge iCLK);
    if (track) check("rd_t3_new", CELLS'(bus.oVAL), CELLS'(newV));
  endtask

  task automatic readAt(input int x, input int y, output logic [PIX_W-1:0] val);
    bus.iRX = COORD_W'(x);
    bus.iRY = COORD_W'(y);
    @(negedge iCLK);
    val = bus.oVAL;
  endtask

  // Reads one pixel per cell at varying in-cell offsets into a bitmap.
  task automatic readAll(input string tag, input logic [CELLS-1:0] exp);
    logic [CELLS-1:0] m;
    logic [PIX_W-1:0] val;
    int               bad;
    bad = 0;
    m   = '0;
    for (int cy = 0; cy < GRID; cy++) begin
      for (int cx = 0; cx < GRID; cx++) begin
        readAt(cx * 16 + ((cx + cy) % 16), cy * 16 + ((cx * 3) % 16), val);
        m[cy * GRID + cx] = (val == WHITE);
        if (val != WHITE && val != BLACK) bad++;
      end
    end
    check(tag, m, exp);
    check({tag, "_enc"}, CELLS'(bad), CELLS'(0));
  endtask

  task automatic runFrame(input int thr, input bit junk,
                          input logic [CELLS-1:0] exp, input string tag);
    int base;
    base = doneCnt;
    arm(thr);
    sendCells(0, GRID - 1, junk);
    endFrame(1'b0, 0, 0);
    check({tag, "_ndone"}, CELLS'(doneCnt - base), CELLS'(1));
    readAll(tag, exp);
  endtask

  initial begin
    iRST_N      = 1'b0;
    bus.iSTART  = 1'b0;
    bus.iTHRESH = '0;
    bus.iDVAL   = 1'b0;
    bus.iX      = '0;
    bus.iY      = '0;
    bus.iGRAY   = '0;
    bus.iRX     = '0;
    bus.iRY     = '0;
    diagMap     = '0;
    for (int i = 0; i < GRID; i++) diagMap[i * GRID + i] = 1'b1;

    repeat (3) @(negedge iCLK);
    check("rst_val", CELLS'(bus.oVAL), CELLS'(0));
    check("rst_busy", CELLS'(bus.oBUSY), CELLS'(0));
    check("rst_done", CELLS'(bus.oDONE), CELLS'(0));
    check("rst_tplok", CELLS'(bus.oTPL_OK), CELLS'(0));
    iRST_N = 1'b1;
    @(negedge iCLK);
    readAll("init_map", '0);

    // 1: 8 x 600 = 4800 -> avg 18; threshold 18 -> all white. Junk ignored.
    setUniform(600, 600);
    runFrame(18, 1'b1, '1, "t1_map");
    check("t1_tplok", CELLS'(bus.oTPL_OK), CELLS'(1));
    readAt(256, 0, v);     check("t1_oob_x", CELLS'(v), CELLS'(BLACK));
    readAt(0, 256, v);     check("t1_oob_y", CELLS'(v), CELLS'(BLACK));
    readAt(8191, 8191, v); check("t1_oob_xy", CELLS'(v), CELLS'(BLACK));
    readAt(255, 255, v);   check("t1_last", CELLS'(v), CELLS'(WHITE));

    // Truncation: 4800/256 = 18.75 truncates to 18 < 19 -> all black.
    runFrame(19, 1'b0, '0, "t1_trunc");

    // 2: iSTART together with an origin beat only arms; a following
    // (255,255) beat must not commit anything.
    bus.iSTART  = 1'b1;
    bus.iTHRESH = 10'd16;
    beat(1'b1, 0, 0, 1023);
    bus.iSTART  = 1'b0;
    d0 = doneCnt;
    beat(1'b1, 15, 15, 1023);
    beat(1'b1, 255, 255, 1023);
    bus.iDVAL = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK);
    check("t2_armed_nodone", CELLS'(doneCnt - d0), CELLS'(0));
    check("t2_armed_busy", CELLS'(bus.oBUSY), CELLS'(1));
    // Diagonal 1023 -> avg 31 >= 16; off-diagonal 10 -> avg 0.
    setDiag(1023, 10);
    sendCells(0, GRID - 1, 1'b0);
    endFrame(1'b0, 0, 0);
    check("t2_ndone", CELLS'(doneCnt - d0), CELLS'(1));
    readAll("t2_map", diagMap);
    readAt(16, 16, v); check("t2_16_16", CELLS'(v), CELLS'(WHITE));
    readAt(16, 0, v);  check("t2_16_0", CELLS'(v), CELLS'(BLACK));

    // 3: 4 x 1023 + 4 x 1 = 4096 -> avg exactly 16.
    setUniform(1023, 1);
    runFrame(16, 1'b0, '1, "t3_equal");
    runFrame(17, 1'b0, '0, "t3_above");

    // 4: old template is all black; watch (0,0) while the new one arrives.
    setUniform(1023, 1023);
    bus.iRX = '0;
    bus.iRY = '0;
    arm(16);
    d0 = doneCnt;
    sendCells(0, 7, 1'b0);
    check("t4_mid_old", CELLS'(bus.oVAL), CELLS'(BLACK));
    sendCells(8, GRID - 1, 1'b0);
    endFrame(1'b1, 0, 255);
    check("t4_ndone", CELLS'(doneCnt - d0), CELLS'(1));
    readAll("t4_map", '1);

    // 5: partial frame up to row 100 with iSTART (thr 0) mid-capture and
    // open row-6 sums, then a full diagonal frame from a restart at (0,0).
    setUniform(1023, 1023);
    arm(16);
    d0 = doneCnt;
    sendCells(0, 1, 1'b0);
    bus.iSTART  = 1'b1;
    bus.iTHRESH = 10'd0;
    beat(1'b1, 5, 40, 1023);
    bus.iSTART  = 1'b0;
    sendCells(2, 5, 1'b0);
    for (int cx = 0; cx < GRID; cx++) begin
      for (int k = 0; k < 8; k++) beat(1'b1, cx * 16 + 3, 100, 1023);
    end
    bus.iDVAL = 1'b0;
    @(negedge iCLK);
    check("t5_partial_nodone", CELLS'(doneCnt - d0), CELLS'(0));
    check("t5_partial_busy", CELLS'(bus.oBUSY), CELLS'(1));
    setDiag(1023, 10);
    sendCells(0, GRID - 1, 1'b0);
    endFrame(1'b0, 0, 0);
    check("t5_ndone", CELLS'(doneCnt - d0), CELLS'(1));
    readAll("t5_map", diagMap);

    // 6: reset pulse in the middle of a capture clears everything.
    setUniform(1023, 1023);
    arm(0);
    sendCells(0, 3, 1'b0);
    iRST_N = 1'b0;
    @(negedge iCLK);
    check("t6_busy", CELLS'(bus.oBUSY), CELLS'(0));
    check("t6_tplok", CELLS'(bus.oTPL_OK), CELLS'(0));
    check("t6_done", CELLS'(bus.oDONE), CELLS'(0));
    check("t6_val", CELLS'(bus.oVAL), CELLS'(0));
    iRST_N = 1'b1;
    @(negedge iCLK);
    readAll("t6_map", '0);
    check("t6_tplok_after", CELLS'(bus.oTPL_OK), CELLS'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
